// File: rtl/keccak_state_unloader_pkg.sv
// Shared definitions for the Keccak state unloader: FSM encodings and default widths.
package keccak_state_unloader_pkg;

  typedef enum logic [1:0] {
    UNL_IDLE = 2'd0,
    UNL_SEND = 2'd1,
    UNL_DONE = 2'd2
  } unl_state_t;

  localparam int KECCAK_STATE_W      = 1600;
  localparam int KECCAK_LANE_W       = 64;
  localparam int SHA3_256_RATE_WORDS = 17;

endpackage

// File: rtl/nbit_dff.sv
// Enabled register with asynchronous active-low reset; holds the unloader's state snapshot.
module nbit_dff #(
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)  q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/keccak_state_unloader.sv
// Snapshots a wide Keccak state on start and streams it out as OUT_WIDTH-bit words.
// Define KECCAK_UNLOAD_BSWAP_EN to emit each word byte-reversed (byte 0 in the MSB).
module keccak_state_unloader
  import keccak_state_unloader_pkg::*;
#(
  parameter int STATE_WIDTH = KECCAK_STATE_W,
  parameter int OUT_WIDTH   = KECCAK_LANE_W,
  parameter int NUM_WORDS   = SHA3_256_RATE_WORDS
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [STATE_WIDTH-1:0] state_in,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_last,
  output logic                   done
);

  localparam int IDXW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NUM_WORDS - 1);

  unl_state_t             st;
  logic [IDXW-1:0]        idx;
  logic [IDXW-1:0]        nxt;
  logic [STATE_WIDTH-1:0] shadow;
  logic [OUT_WIDTH-1:0]   nxt_word;
  logic                   capture;

  assign capture  = (st == UNL_IDLE) && start;
  assign nxt      = idx + IDXW'(1);
  // Only read while idx < LAST, so the select never runs past the snapshot.
  assign nxt_word = shadow[32'(nxt)*OUT_WIDTH +: OUT_WIDTH];

  nbit_dff #(.DATA_WIDTH(STATE_WIDTH)) u_shadow (
    .clk    (clk),
    .resetn (resetn),
    .en     (capture),
    .d      (state_in),
    .q      (shadow)
  );

  function automatic logic [OUT_WIDTH-1:0] fmt(input logic [OUT_WIDTH-1:0] w);
    fmt = '0;
`ifdef KECCAK_UNLOAD_BSWAP_EN
    for (int b = 0; b < OUT_WIDTH/8; b++)
      fmt[OUT_WIDTH-8-8*b +: 8] = w[8*b +: 8];
`else
    fmt = w;
`endif
  endfunction

  // Word 0 is taken straight from state_in on the capture edge so it is
  // presented in the very next cycle; later words come from the snapshot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st        <= UNL_IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (st)
        UNL_IDLE: begin
          done <= 1'b0;
          if (start) begin
            st        <= UNL_SEND;
            idx       <= '0;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_data  <= fmt(state_in[OUT_WIDTH-1:0]);
            out_last  <= (NUM_WORDS == 1);
          end
        end
        UNL_SEND: begin
          if (out_ready) begin
            if (idx == LAST) begin
              st        <= UNL_DONE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              idx      <= nxt;
              out_data <= fmt(nxt_word);
              out_last <= (nxt == LAST);
            end
          end
        end
        UNL_DONE: begin
          st   <= UNL_IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: st <= UNL_IDLE;
      endcase
    end
  end

endmodule
